// File: rtl/neighbor_best_scan_pkg.sv
// Shared constants for the neighbour Q-table scan and the policy stage that consumes it.
// Latency: n/a (constants only).
// Backpressure: n/a.
package neighbor_best_scan_pkg;

    localparam int QR_WORD_WIDTH   = 16;
    localparam int QR_ADDR_WIDTH   = 10;
    localparam int QR_MEM_DEPTH    = 1 << QR_ADDR_WIDTH;
    localparam int QR_ENTRY_STRIDE = 4;

    // Value reported as the winning ID when no entry was taken.
    localparam logic [QR_WORD_WIDTH-1:0] QR_NO_NEIGHBOR = 16'hFFFF;

    // Scan FSM encodings; kept as plain constants so the policy stage can share them.
    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_RD_ID  = 3'd1;
    localparam logic [2:0] ST_RD_VAL = 3'd2;
    localparam logic [2:0] ST_CMP    = 3'd3;
    localparam logic [2:0] ST_DONE   = 3'd4;

endpackage

// File: rtl/q_best_update.sv
// Combinational decision: should a candidate entry replace the current best?
// Latency: 0 cycles (pure combinational). Optional macro: SCAN_SKIP_SELF_EN.
// Backpressure: none; caller decides when the result is used.
module q_best_update #(
    parameter int WORD_WIDTH = 16
) (
    input  logic [WORD_WIDTH-1:0] cand_id_i,
    input  logic [WORD_WIDTH-1:0] cand_val_i,
    input  logic [WORD_WIDTH-1:0] best_val_i,
    input  logic                  best_vld_i,
    input  logic [WORD_WIDTH-1:0] my_id_i,
    output logic                  take_new_o
);

    logic eligible;
    logic better;

`ifdef SCAN_SKIP_SELF_EN
    // Our own entry never wins, but it is still read so timing does not change.
    assign eligible = (cand_id_i != my_id_i);
`else
    logic unused_my_id;
    assign unused_my_id = ^my_id_i;
    assign eligible     = 1'b1;
`endif

    // Strict greater-than keeps the earlier entry on ties; first eligible entry always wins.
    assign better     = !best_vld_i || (cand_val_i > best_val_i);
    assign take_new_o = eligible && better;

endmodule

// File: rtl/neighbor_best_scan.sv
// Scans the neighbour Q-table in memory and reports the neighbour with the largest Q-value.
// Latency: 3 cycles per entry; done pulses in cycle 3N+1 after start is sampled (cycle 1 if N=0).
// Backpressure: none; start while busy is ignored. Optional macro: SCAN_SKIP_SELF_EN.
module neighbor_best_scan #(
    parameter int WORD_WIDTH = neighbor_best_scan_pkg::QR_WORD_WIDTH,
    parameter int ADDR_WIDTH = neighbor_best_scan_pkg::QR_ADDR_WIDTH,
    parameter int STRIDE     = neighbor_best_scan_pkg::QR_ENTRY_STRIDE
) (
    input  logic                  clock,
    input  logic                  nreset,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [WORD_WIDTH-1:0] neighbor_count,
    input  logic [WORD_WIDTH-1:0] MY_NODE_ID,
    output logic                  mem_rd_en,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [WORD_WIDTH-1:0] mem_rdata,
    output logic                  busy,
    output logic                  done,
    output logic [WORD_WIDTH-1:0] bestvalue,
    output logic [WORD_WIDTH-1:0] bestneighborID
);

    import neighbor_best_scan_pkg::*;

    localparam logic [WORD_WIDTH-1:0] NONE    = {WORD_WIDTH{1'b1}};
    localparam logic [ADDR_WIDTH-1:0] STEP    = ADDR_WIDTH'(STRIDE);
    localparam logic [ADDR_WIDTH-1:0] VAL_OFS = ADDR_WIDTH'(WORD_WIDTH / 8);

    logic [2:0]            state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [WORD_WIDTH-1:0] idx_q, n_q, cand_id_q;
    logic [WORD_WIDTH-1:0] best_val_q, best_id_q;
    logic                  best_vld_q;
    logic [WORD_WIDTH-1:0] idx_nxt;
    logic                  take_new;

    assign idx_nxt = idx_q + WORD_WIDTH'(1);

    // Value word arrives in CMP; the ID word was captured the cycle before.
    q_best_update #(
        .WORD_WIDTH (WORD_WIDTH)
    ) u_best_update (
        .cand_id_i  (cand_id_q),
        .cand_val_i (mem_rdata),
        .best_val_i (best_val_q),
        .best_vld_i (best_vld_q),
        .my_id_i    (MY_NODE_ID),
        .take_new_o (take_new)
    );

    // Next-state: ID read, value read, compare per entry; empty table goes straight to DONE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (start) state_d = (neighbor_count == '0) ? ST_DONE : ST_RD_ID;
            ST_RD_ID:  state_d = ST_RD_VAL;
            ST_RD_VAL: state_d = ST_CMP;
            ST_CMP:    state_d = (idx_nxt == n_q) ? ST_DONE : ST_RD_ID;
            ST_DONE:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // State register; reset aborts any scan in flight.
    always_ff @(posedge clock or posedge nreset) begin
        if (nreset) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Scan bookkeeping: table pointer, entry index, latched count and captured ID.
    always_ff @(posedge clock or posedge nreset) begin
        if (nreset) begin
            addr_q    <= '0;
            idx_q     <= '0;
            n_q       <= '0;
            cand_id_q <= '0;
        end else begin
            if (state_q == ST_IDLE && start) begin
                addr_q <= base_addr;
                idx_q  <= '0;
                n_q    <= neighbor_count;
            end
            if (state_q == ST_RD_VAL) cand_id_q <= mem_rdata;
            if (state_q == ST_CMP) begin
                idx_q  <= idx_nxt;
                addr_q <= addr_q + STEP;   // wraps modulo the address space
            end
        end
    end

    // Running best: cleared on an accepted start, updated only while comparing.
    always_ff @(posedge clock or posedge nreset) begin
        if (nreset) begin
            best_val_q <= '0;
            best_id_q  <= NONE;
            best_vld_q <= 1'b0;
        end else if (state_q == ST_IDLE && start) begin
            best_val_q <= '0;
            best_id_q  <= NONE;
            best_vld_q <= 1'b0;
        end else if (state_q == ST_CMP && take_new) begin
            best_val_q <= mem_rdata;
            best_id_q  <= cand_id_q;
            best_vld_q <= 1'b1;
        end
    end

    assign mem_rd_en      = (state_q == ST_RD_ID) || (state_q == ST_RD_VAL);
    assign mem_addr       = (state_q == ST_RD_ID)  ? addr_q :
                            (state_q == ST_RD_VAL) ? addr_q + VAL_OFS : '0;
    assign busy           = (state_q == ST_RD_ID) || (state_q == ST_RD_VAL) || (state_q == ST_CMP);
    assign done           = (state_q == ST_DONE);
    assign bestvalue      = best_val_q;
    assign bestneighborID = best_id_q;

endmodule

// File: tb/tb_neighbor_best_scan.sv
// Scoreboard bench for neighbor_best_scan: directed tables, expected results queued at issue.
// Latency: checks done cycle against 3N+1 and every memory address in order.
// Backpressure: n/a; all waits on the DUT are bounded.
`timescale 1ns/1ps
module tb_neighbor_best_scan;

    logic        clock = 1'b0;
    logic        nreset = 1'b1;
    logic        start = 1'b0;
    logic [9:0]  base_addr = '0;
    logic [15:0] neighbor_count = '0;
    logic [15:0] MY_NODE_ID = 16'd6;
    logic        mem_rd_en;
    logic [9:0]  mem_addr;
    logic [15:0] mem_rdata = '0;
    logic        busy, done;
    logic [15:0] bestvalue, bestneighborID;

    neighbor_best_scan dut (
        .clock          (clock),
        .nreset         (nreset),
        .start          (start),
        .base_addr      (base_addr),
        .neighbor_count (neighbor_count),
        .MY_NODE_ID     (MY_NODE_ID),
        .mem_rd_en      (mem_rd_en),
        .mem_addr       (mem_addr),
        .mem_rdata      (mem_rdata),
        .busy           (busy),
        .done           (done),
        .bestvalue      (bestvalue),
        .bestneighborID (bestneighborID)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    // Byte-wide memory, little-endian 16-bit words, one-cycle read latency.
    logic [7:0] mem [0:1023];
    logic [9:0] rd_hi;
    assign rd_hi = mem_addr + 10'd1;
    always @(posedge clock) if (mem_rd_en) mem_rdata <= {mem[rd_hi], mem[mem_addr]};

    typedef struct {
        logic [15:0] id;
        logic [15:0] val;
        int          lat;
        int          reads;
        int          start_edge;
    } exp_t;

    exp_t       exp_q[$];
    logic [9:0] addr_exp_q[$];
    bit         addr_chk_en = 1'b1;
    int         n_checks = 0;
    int         n_fail = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, req);
        end
    endtask

    task automatic put_entry(input logic [9:0] a, input logic [15:0] id, input logic [15:0] v);
        logic [9:0] p;
        p = a;          mem[p] = id[7:0];
        p = p + 10'd1;  mem[p] = id[15:8];
        p = p + 10'd1;  mem[p] = v[7:0];
        p = p + 10'd1;  mem[p] = v[15:8];
    endtask

    task automatic push_exp(input logic [9:0] base, input int n, input logic [15:0] id,
                            input logic [15:0] val, input int sedge);
        exp_t e;
        logic [9:0] a;
        e.id = id; e.val = val; e.lat = 3 * n + 1; e.reads = 2 * n; e.start_edge = sedge;
        exp_q.push_back(e);
        a = base;
        for (int i = 0; i < n; i++) begin
            addr_exp_q.push_back(a);
            addr_exp_q.push_back(a + 10'd2);
            a = a + 10'd4;
        end
    endtask

    // Called at a negedge; start is sampled on the next rising edge.
    task automatic issue(input logic [9:0] base, input int n, input logic [15:0] id, input logic [15:0] val);
        base_addr      = base;
        neighbor_count = 16'(n);
        start          = 1'b1;
        push_exp(base, n, id, val, cyc + 1);
        @(negedge clock);
        start = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        for (int i = 0; i < budget && exp_q.size() != 0; i++) @(negedge clock);
        check("scan_timeout_pending", exp_q.size(), 0);
        exp_q.delete();
        @(negedge clock);
    endtask

    // Monitor: checks every read address and every done pulse against the queues.
    initial begin
        int   rd_cnt;
        exp_t e;
        rd_cnt = 0;
        forever begin
            @(negedge clock);
            if (nreset) begin
                rd_cnt = 0;
            end else begin
                if (mem_rd_en) begin
                    rd_cnt++;
                    if (addr_chk_en) begin
                        if (addr_exp_q.size() == 0) check("read_unexpected", 32'(mem_addr), 32'hFFFF_FFFF);
                        else check("read_addr", 32'(mem_addr), 32'(addr_exp_q.pop_front()));
                    end
                end
                if (done) begin
                    if (exp_q.size() == 0) begin
                        check("done_unexpected", 32'(bestneighborID), 32'hFFFF_FFFF);
                    end else begin
                        e = exp_q.pop_front();
                        check("best_id",   32'(bestneighborID), 32'(e.id));
                        check("best_val",  32'(bestvalue),      32'(e.val));
                        check("done_cycle", cyc - e.start_edge + 1, e.lat);
                        check("read_count", rd_cnt, e.reads);
                    end
                    rd_cnt = 0;
                end
            end
        end
    end

    initial begin
        int d_seen;
        // Table contents
        put_entry(10'd16,  16'd5, 16'h0100);
        put_entry(10'd20,  16'd7, 16'h0300);
        put_entry(10'd24,  16'd9, 16'h0200);
        put_entry(10'd64,  16'd4, 16'h0080);
        put_entry(10'd68,  16'd2, 16'h0080);
        put_entry(10'd128, 16'd6, 16'hFFFF);
        put_entry(10'd132, 16'd3, 16'h0010);
        put_entry(10'd200, 16'h0A, 16'h0010);
        put_entry(10'd204, 16'h0B, 16'h0020);
        put_entry(10'd208, 16'h0C, 16'h0030);
        put_entry(10'd212, 16'h0D, 16'h0040);
        put_entry(10'd1020, 16'h11, 16'h0500);
        put_entry(10'd0,    16'h22, 16'h0900);
        put_entry(10'd300, 16'd1, 16'h7FFF);
        put_entry(10'd304, 16'd2, 16'h8000);
        put_entry(10'd308, 16'd3, 16'h0001);
        put_entry(10'd312, 16'd4, 16'h8000);

        // Reset state
        repeat (2) @(negedge clock);
        check("rst_busy",   32'(busy),           0);
        check("rst_done",   32'(done),           0);
        check("rst_rd_en",  32'(mem_rd_en),      0);
        check("rst_addr",   32'(mem_addr),       0);
        check("rst_value",  32'(bestvalue),      0);
        check("rst_id",     32'(bestneighborID), 32'hFFFF);
        nreset = 1'b0;
        repeat (2) @(negedge clock);

        // Basic three-entry scan
        issue(10'd16, 3, 16'd7, 16'h0300);
        wait_idle(100);

        // Empty table clears the previous result
        issue(10'd0, 0, 16'hFFFF, 16'h0000);
        wait_idle(100);

        // Tie: first entry wins; start held high re-triggers right after DONE
        base_addr      = 10'd64;
        neighbor_count = 16'd2;
        start          = 1'b1;
        push_exp(10'd64, 2, 16'd4, 16'h0080, cyc + 1);
        d_seen = 0;
        for (int i = 0; i < 50 && d_seen == 0; i++) begin
            @(negedge clock);
            if (done) d_seen = 1;
        end
        check("hold_first_done_seen", d_seen, 1);
        push_exp(10'd64, 2, 16'd4, 16'h0080, cyc + 2);
        repeat (2) @(negedge clock);
        start = 1'b0;
        wait_idle(100);

        // Own-ID entry
`ifdef SCAN_SKIP_SELF_EN
        issue(10'd128, 2, 16'd3, 16'h0010);
`else
        issue(10'd128, 2, 16'd6, 16'hFFFF);
`endif
        wait_idle(100);

        // Reset during the second entry of a four-entry scan
        addr_chk_en    = 1'b0;
        base_addr      = 10'd200;
        neighbor_count = 16'd4;
        start          = 1'b1;
        @(negedge clock);
        start = 1'b0;
        repeat (3) @(negedge clock);
        check("abort_pre_id",   32'(bestneighborID), 32'h000A);
        check("abort_pre_val",  32'(bestvalue),      32'h0010);
        check("abort_pre_busy", 32'(busy),           1);
        @(negedge clock);
        #2 nreset = 1'b1;
        #1;
        check("abort_busy",  32'(busy),           0);
        check("abort_done",  32'(done),           0);
        check("abort_rd_en", 32'(mem_rd_en),      0);
        check("abort_addr",  32'(mem_addr),       0);
        check("abort_value", 32'(bestvalue),      0);
        check("abort_id",    32'(bestneighborID), 32'hFFFF);
        @(negedge clock);
        nreset = 1'b0;
        @(negedge clock);
        addr_chk_en = 1'b1;
        issue(10'd200, 4, 16'h000D, 16'h0040);
        wait_idle(100);

        // Address wrap: second entry sits at bytes 0..3
        issue(10'd1020, 2, 16'h0022, 16'h0900);
        wait_idle(100);

        // Unsigned compare, strict update on equal top values
        issue(10'd300, 4, 16'd2, 16'h8000);
        wait_idle(100);

        check("addr_queue_empty", addr_exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
